rr_arbiter4: RTL and testbench

- 4-requester round-robin arbiter that shares one downstream resource (e.g. the 4-input encoder datapath or a shared bus) among up to 4 clients.
- A granted requester keeps its grant until it drops its request.
- Selection is by a rotating-priority pick, which is a priority encoder over a rotated request vector.
- Sits between the request sources and the shared resource; drives a one-hot grant, an encoded grant index and a valid flag.

---
 rtl/arb_pkg.sv | 20 ++
 rtl/rr_pick4.sv | 34 +++
 rtl/rr_arbiter4.sv | 107 ++++++++++
 tb/tb_rr_arbiter4.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types and helpers for the 4-way round-robin arbiter.
package arb_pkg;

    localparam int N_REQ  = 4;
    localparam int IDX_W  = 2;
    localparam int HOLD_W = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    function automatic logic [N_REQ-1:0] onehot4(input logic [IDX_W-1:0] idx);
        logic [N_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// Rotating-priority pick: rotate requests right by ptr, take the lowest set
// index, then add ptr back. Optionally masks one index out of the candidates.
module rr_pick4
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] i_req,
    input  logic [IDX_W-1:0] i_ptr,
    input  logic [IDX_W-1:0] i_mask_idx,
    input  logic             i_mask_en,
    output logic [IDX_W-1:0] o_win_idx,
    output logic             o_win_any
);

    logic [N_REQ-1:0]   w_masked;
    logic [2*N_REQ-1:0] w_dbl;
    logic [N_REQ-1:0]   w_rot;
    logic [IDX_W-1:0]   w_enc;

    assign w_masked = i_req & ~(i_mask_en ? onehot4(i_mask_idx) : '0);
    assign w_dbl    = {w_masked, w_masked};
    assign w_rot    = w_dbl[i_ptr +: N_REQ];

    // NOTE: default first so every path assigns w_enc; otherwise a latch is inferred.
    always_comb begin
        w_enc = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (w_rot[k]) w_enc = IDX_W'(k);
        end
    end

    assign o_win_idx = w_enc + i_ptr;
    assign o_win_any = |w_rot;

endmodule

// File: rtl/rr_arbiter4.sv
// 4-requester round-robin arbiter with hold-until-release ownership.
// Define ARB_TIMEOUT_EN to preempt an owner after HOLD_MAX cycles when others wait.
module rr_arbiter4
    import arb_pkg::*;
#(
    parameter int HOLD_MAX = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid
);

    if (HOLD_MAX < 2 || HOLD_MAX > 255) begin : g_bad_hold_max
        $error("rr_arbiter4: HOLD_MAX must be in 2..255");
    end

    state_t           r_state;
    logic [IDX_W-1:0] r_ptr;
    logic [N_REQ-1:0] r_gnt;
    logic [IDX_W-1:0] r_gnt_idx;
    logic             r_gnt_valid;

    logic [IDX_W-1:0] w_pick_ptr;
    logic [IDX_W-1:0] w_win_idx;
    logic             w_win_any;
    logic             w_preempt;
    logic             w_handoff;

    // In GRANT the pick only matters on a handoff, where the new ptr is owner+1.
    assign w_pick_ptr = (r_state == GRANT) ? r_gnt_idx + 2'd1 : r_ptr;

    rr_pick4 u_pick (
        .i_req      (req),
        .i_ptr      (w_pick_ptr),
        .i_mask_idx (r_gnt_idx),
        .i_mask_en  (r_state == GRANT),
        .o_win_idx  (w_win_idx),
        .o_win_any  (w_win_any)
    );

`ifdef ARB_TIMEOUT_EN
    logic [HOLD_W-1:0] r_hold;

    // w_win_any already excludes the owner, so it means "someone else waits".
    assign w_preempt = (r_hold == HOLD_W'(HOLD_MAX - 1)) && w_win_any;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold <= '0;
        end else if (r_state == IDLE || w_handoff) begin
            r_hold <= '0;
        end else if (r_hold != HOLD_W'(HOLD_MAX - 1)) begin
            r_hold <= r_hold + 1'b1;
        end
    end
`else
    assign w_preempt = 1'b0;
`endif

    assign w_handoff = (r_state == GRANT) && (!req[r_gnt_idx] || w_preempt);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_ptr       <= '0;
            r_gnt       <= '0;
            r_gnt_idx   <= '0;
            r_gnt_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_win_any) begin
                        r_gnt       <= onehot4(w_win_idx);
                        r_gnt_idx   <= w_win_idx;
                        r_gnt_valid <= 1'b1;
                        r_state     <= GRANT;
                    end
                end
                GRANT: begin
                    if (w_handoff) begin
                        r_ptr <= r_gnt_idx + 2'd1;
                        if (w_win_any) begin
                            r_gnt     <= onehot4(w_win_idx);
                            r_gnt_idx <= w_win_idx;
                        end else begin
                            r_gnt       <= '0;
                            r_gnt_idx   <= '0;
                            r_gnt_valid <= 1'b0;
                            r_state     <= IDLE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign gnt       = r_gnt;
    assign gnt_idx   = r_gnt_idx;
    assign gnt_valid = r_gnt_valid;

endmodule

// File: tb/tb_rr_arbiter4.sv
// Scoreboard bench for rr_arbiter4: the driver pushes model predictions, a
// monitor pops one per rising edge and compares against the DUT outputs.
module tb_rr_arbiter4;

    localparam int HOLD_MAX = 4;
`ifdef ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       clk = 1'b1;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] gnt_idx;
    logic       gnt_valid;

    int n_cmp = 0;
    int n_bad = 0;

    logic [6:0] exp_q[$];

    // Reference model: owner (-1 = none), rotation start, cycles held.
    int m_owner = -1;
    int m_ptr   = 0;
    int m_hold  = 0;

    rr_arbiter4 #(.HOLD_MAX(HOLD_MAX)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got gnt/idx/valid=%b/%b/%b, want %b/%b/%b", name, $time,
                     act[6:3], act[2:1], act[0], exp[6:3], exp[2:1], exp[0]);
        end
    endtask

    function automatic logic [6:0] model_out();
        logic [3:0] g;
        logic [1:0] ix;
        g  = 4'b0000;
        ix = 2'd0;
        if (m_owner >= 0) begin
            g[m_owner] = 1'b1;
            ix         = 2'(m_owner);
        end
        return {g, ix, (m_owner >= 0)};
    endfunction

    // First requester found scanning from start upward (mod 4), skipping skip_idx.
    function automatic int first_from(input logic [3:0] r, input int start, input int skip_idx);
        int found;
        found = -1;
        for (int k = 0; k < 4; k++) begin
            int i;
            i = (start + k) % 4;
            if (found < 0 && r[i] && i != skip_idx) found = i;
        end
        return found;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = 0;
        m_hold  = 0;
    endtask

    task automatic model_edge(input logic [3:0] r);
        if (m_owner < 0) begin
            m_owner = first_from(r, m_ptr, -1);
            m_hold  = 0;
        end else begin
            bit others;
            bit preempt;
            int old;
            others  = ((r & ~(4'b0001 << m_owner)) != 4'b0000);
            preempt = TO_EN && (m_hold == HOLD_MAX - 1) && others;
            if (!r[m_owner] || preempt) begin
                old     = m_owner;
                m_ptr   = (old + 1) % 4;
                m_owner = first_from(r, m_ptr, old);
                m_hold  = 0;
            end else if (m_hold < HOLD_MAX - 1) begin
                m_hold++;
            end
        end
    endtask

    task automatic step(input logic [3:0] r, input logic rst_val);
        @(negedge clk);
        req   = r;
        rst_n = rst_val;
        if (!rst_val) model_reset();
        else model_edge(r);
        exp_q.push_back(model_out());
    endtask

    task automatic async_reset_pulse();
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check("async_reset", {gnt, gnt_idx, gnt_valid}, 7'b0);
        model_reset();
        #1 rst_n = 1'b1;
    endtask

    initial begin : monitor
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL scoreboard_empty @%0t: no prediction queued", $time);
            end else begin
                check("grant", {gnt, gnt_idx, gnt_valid}, exp_q.pop_front());
                n_cmp++;
                if (gnt_valid !== (|gnt) || (gnt & (gnt - 4'd1)) !== 4'b0000) begin
                    n_bad++;
                    $display("FAIL invariant @%0t: gnt=%b valid=%b", $time, gnt, gnt_valid);
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        logic [3:0] r;
        rst_n = 1'b0;
        req   = 4'b1111;

        // Reset with all requesting, then release idle.
        step(4'b1111, 1'b0);
        step(4'b1111, 1'b0);
        repeat (3) step(4'b0000, 1'b1);

        // Single request, hold, release.
        step(4'b0100, 1'b1);
        repeat (5) step(4'b0100, 1'b1);
        step(4'b0000, 1'b1);
        step(4'b0000, 1'b1);

        // Wrap/priority from a fresh reset.
        step(4'b0000, 1'b0);
        step(4'b1010, 1'b1);
        step(4'b1010, 1'b1);
        step(4'b1000, 1'b1);
        step(4'b1000, 1'b1);
        step(4'b0000, 1'b1);
        step(4'b0011, 1'b1);
        step(4'b0011, 1'b1);

        // Rotation after reset: each owner drops for one cycle.
        step(4'b0000, 1'b0);
        step(4'b1111, 1'b1);
        for (int i = 0; i < 10; i++) begin
            r = 4'b1111;
            if (m_owner >= 0) r[m_owner] = 1'b0;
            step(r, 1'b1);
            step(4'b1111, 1'b1);
        end

        // Async reset with owner 2, then all request.
        step(4'b0000, 1'b0);
        step(4'b0100, 1'b1);
        step(4'b0100, 1'b1);
        async_reset_pulse();
        step(4'b1111, 1'b1);
        step(4'b1111, 1'b1);
        step(4'b0000, 1'b1);

`ifdef ARB_TIMEOUT_EN
        step(4'b0000, 1'b0);
        repeat (10) step(4'b0011, 1'b1);
        step(4'b0000, 1'b1);
        repeat (10) step(4'b0001, 1'b1);
        step(4'b0011, 1'b1);
        step(4'b0000, 1'b1);
`endif

        // Randomized traffic; the owner usually keeps its request up.
        for (int i = 0; i < 600; i++) begin
            r = 4'($urandom);
            if (m_owner >= 0 && $urandom_range(3) != 0) r[m_owner] = 1'b1;
            if (i % 150 == 149) async_reset_pulse();
            step(r, 1'b1);
        end

        @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL leftover_predictions: %0d left, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
